// File: rtl/stack_tnp.sv
// Forth data/return stack with T/N/P cached in registers and deeper entries spilled
// to a single-port synchronous RAM. POP refills P and deep PICK fetches T, one busy cycle each.
module stack_tnp #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] vi,
  input  logic [SSZ-1:0] idx,
  output logic [DSZ-1:0] t,
  output logic [DSZ-1:0] n,
  output logic [SSZ:0]   depth,
  output logic           busy,
  output logic           ovf,
  output logic           udf
);

  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_DUP   = 3'b011;
  localparam logic [2:0] OP_SWAP  = 3'b100;
  localparam logic [2:0] OP_OVER  = 3'b101;
  localparam logic [2:0] OP_PICK  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [SSZ:0] D_MAX = (SSZ+1)'(DEPTH);
  localparam logic [SSZ:0] D2    = (SSZ+1)'(2);
  localparam logic [SSZ:0] D3    = (SSZ+1)'(3);
  localparam logic [SSZ:0] D4    = (SSZ+1)'(4);

  typedef enum logic [1:0] {IDLE, FILL, PRD} state_t;

  state_t         state;
  logic [DSZ-1:0] p;
  logic [DSZ-1:0] spill;
  logic [DSZ-1:0] rdata;
  logic [DSZ-1:0] mem [DEPTH];

  logic           accept;
  logic           is_push;
  logic           pick_ram;
  logic           err_ovf;
  logic           err_udf;
  logic           ok;
  logic [SSZ-1:0] rp;
  logic [DSZ-1:0] push_val;
  logic           ram_we;
  logic           ram_re;
  logic [SSZ-1:0] ram_addr;
  logic [DSZ-1:0] ram_wdata;

  assign busy = (state != IDLE);
  assign rp   = (depth >= D3) ? SSZ'(depth - D3) : '0;

  always_comb begin
    accept   = en && (state == IDLE);
    is_push  = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER) || (op == OP_PICK);
    pick_ram = (op == OP_PICK) && (idx >= SSZ'(3));
    err_ovf  = accept && is_push && (depth == D_MAX);
    err_udf  = accept && (((op == OP_POP)  && (depth == '0)) ||
                          ((op == OP_DUP)  && (depth == '0)) ||
                          (((op == OP_SWAP) || (op == OP_OVER)) && (depth < D2)) ||
                          ((op == OP_PICK) && ({1'b0, idx} >= depth)));
    ok       = accept && !err_ovf && !err_udf;

    push_val = vi;
    case (op)
      OP_DUP:  push_val = t;
      OP_OVER: push_val = n;
      OP_PICK: begin
        if (idx == SSZ'(1))      push_val = n;
        else if (idx == SSZ'(2)) push_val = p;
        else                     push_val = t;  // idx 0, or interim value until PRD loads T
      end
      default: push_val = vi;
    endcase

    // A deep PICK reads in the accept cycle, so the spill of the old P is
    // deferred to the PRD cycle to keep the RAM port free of collisions.
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = p;
    if (state == PRD) begin
      ram_we    = 1'b1;
      ram_addr  = SSZ'(depth - D4);
      ram_wdata = spill;
    end else if (ok) begin
      if (pick_ram) begin
        ram_re   = 1'b1;
        ram_addr = rp + SSZ'(2) - idx;
      end else if (is_push && (depth >= D3)) begin
        ram_we   = 1'b1;
        ram_addr = rp;
      end else if ((op == OP_POP) && (rp != '0)) begin
        ram_re   = 1'b1;
        ram_addr = rp - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) rdata <= mem[ram_addr];
    if (ok && pick_ram) spill <= p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
      n     <= '0;
      p     <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          p     <= rdata;
          state <= IDLE;
        end
        PRD: begin
          t     <= rdata;
          state <= IDLE;
        end
        default: begin
          if (err_ovf) ovf <= 1'b1;
          if (err_udf) udf <= 1'b1;
          if (ok) begin
            case (op)
              OP_PUSH, OP_DUP, OP_OVER, OP_PICK: begin
                p     <= n;
                n     <= t;
                t     <= push_val;
                depth <= depth + 1'b1;
                if (pick_ram) state <= PRD;
              end
              OP_POP: begin
                t     <= n;
                n     <= p;
                p     <= '0;
                depth <= depth - 1'b1;
                if (rp != '0) state <= FILL;
              end
              OP_SWAP: begin
                t <= n;
                n <= t;
              end
              OP_CLEAR: begin
                t     <= '0;
                n     <= '0;
                p     <= '0;
                depth <= '0;
                ovf   <= 1'b0;
                udf   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(ram_we && ram_re)) else $error("stack_tnp: RAM read and write in same cycle");
  end

endmodule
